// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the RAM data-port arbiter: FSM state encoding,
// port indices, lock timeout length and the peripheral buffer address.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_PERIPH = 1'b1;

  // Idle cycles without a request from the lock owner before the lock is dropped.
  localparam int LOCK_TIMEOUT = 16;

  // Word address of the RAM-side peripheral buffer; no special handling here,
  // listed so the address map lives in one place.
  localparam logic [15:0] PERIPH_BUF_ADDR = 16'hFFFE;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin picker. The grant is combinational from the request
// vector; the last-grant pointer is registered and advances only when the
// caller accepts the grant. A held lock restricts the grant to its owner.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_req[1:0]       request per port
//   i_lock_held      a lock is active
//   i_lock_owner     port owning the lock
//   i_update         grant is being taken this cycle; advance pointer
//   o_grant_valid    some port may be granted
//   o_grant_idx      index of the granted port
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_lock_held,
  input  logic       i_lock_owner,
  input  logic       i_update,
  output logic       o_grant_valid,
  output logic       o_grant_idx
);

  logic r_last;

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = PORT_CPU;
    if (i_lock_held) begin
      // While locked the other port waits even if it is requesting.
      o_grant_valid = i_req[i_lock_owner];
      o_grant_idx   = i_lock_owner;
    end else if (i_req == 2'b11) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = other_port(r_last);
    end else if (i_req[0]) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = PORT_CPU;
    end else if (i_req[1]) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = PORT_PERIPH;
    end
  end

  // Reset to "port 1 granted last" so a first tie goes to port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT_PERIPH;
    end else if (i_update && o_grant_valid) begin
      r_last <= o_grant_idx;
    end
  end

endmodule

// File: rtl/ram_data_arbiter.sv
// ram_data_arbiter
// Shares the RAM's 16-bit data port between the CPU load/store unit (port 0)
// and the peripheral/IO engine (port 1). Each transfer is IDLE -> ACCESS ->
// ACK, so at most one transfer every three cycles. A port may lock the grant
// for read-modify-write; the lock drops when the owner finishes an access
// with lock low, or after LOCK_TIMEOUT idle cycles without an owner request.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req*/we*/lock*/addr*/wdata* master request side
//   ack0, ack1                 one-cycle completion pulse per port
//   rdata                      read word (write word on writes), held between acks
//   ram_addr/ram_wdata/ram_we  RAM data-port drive, zero outside ACCESS
//   ram_rdata                  RAM combinational read data
//   busy                       transfer in flight or lock held
module ram_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_EN    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic                    lock0,
  input  logic                    lock1,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [2*DATA_WIDTH-1:0] wdata0,
  input  logic [2*DATA_WIDTH-1:0] wdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [2*DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [2*DATA_WIDTH-1:0] ram_wdata,
  output logic                    ram_we,
  input  logic [2*DATA_WIDTH-1:0] ram_rdata,
  output logic                    busy
);

  localparam int   WW      = 2 * DATA_WIDTH;
  localparam logic LOCK_ON = (LOCK_EN != 0);
  localparam logic [3:0] TMO_LAST = 4'(LOCK_TIMEOUT - 1);

  arb_state_t r_state, w_next;

  logic                  r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WW-1:0]         r_wdata;
  logic                  r_we;
  logic                  r_lock;
  logic [3:0]            r_tmo;
  logic [WW-1:0]         r_rdata;
  logic                  r_ack0;
  logic                  r_ack1;

  logic w_grant_valid;
  logic w_grant_idx;
  logic w_take;
  logic w_owner_req;

  rr_arb2 u_rr (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         ({req1, req0}),
    .i_lock_held   (r_lock),
    .i_lock_owner  (r_owner),
    .i_update      (w_take),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_take      = (r_state == ST_IDLE) && w_grant_valid;
  assign w_owner_req = r_owner ? req1 : req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant_valid) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_ACK;
      ST_ACK:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= PORT_CPU;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_lock  <= 1'b0;
      r_tmo   <= '0;
      r_rdata <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (w_take) begin
        r_owner <= w_grant_idx;
        r_addr  <= w_grant_idx ? addr1  : addr0;
        r_wdata <= w_grant_idx ? wdata1 : wdata0;
        r_we    <= w_grant_idx ? we1    : we0;
        r_lock  <= LOCK_ON & (w_grant_idx ? lock1 : lock0);
        r_tmo   <= '0;
      end else if ((r_state == ST_IDLE) && r_lock && !w_owner_req) begin
        // Counts consecutive owner-idle cycles; any owner request is granted
        // and resets the count above.
        if (r_tmo == TMO_LAST) begin
          r_lock <= 1'b0;
          r_tmo  <= '0;
        end else begin
          r_tmo <= r_tmo + 4'd1;
        end
      end
      if (r_state == ST_ACCESS) begin
        r_rdata <= r_we ? r_wdata : ram_rdata;
        if (r_owner) r_ack1 <= 1'b1;
        else         r_ack0 <= 1'b1;
      end
    end
  end

  // RAM drive decoded from state so an async reset kills ram_we at once.
  assign ram_addr  = (r_state == ST_ACCESS) ? r_addr  : '0;
  assign ram_wdata = (r_state == ST_ACCESS) ? r_wdata : '0;
  assign ram_we    = (r_state == ST_ACCESS) && r_we;

  assign ack0  = r_ack0;
  assign ack1  = r_ack1;
  assign rdata = r_rdata;
  assign busy  = (r_state != ST_IDLE) || r_lock;

endmodule

// File: tb/tb_ram_data_arbiter.sv
// tb_ram_data_arbiter
// Directed bench for ram_data_arbiter with a byte-wide RAM model (little-endian
// 16-bit port, wrapping address, peripheral buffer at 0xFFFE).
module tb_ram_data_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic [15:0] periph_buf;
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_byte;
  int          we_cnt;
  logic [15:0] w_addr_p1;

  int errors = 0;
  int checks = 0;

  ram_data_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .LOCK_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_addr_p1 = ram_addr + 16'd1;
  assign ram_rdata = {mem[w_addr_p1], mem[ram_addr]};

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_byte;
    if (ram_we) begin
      mem[ram_addr]  <= ram_wdata[7:0];
      mem[w_addr_p1] <= ram_wdata[15:8];
      we_cnt         <= we_cnt + 1;
      if (ram_addr == 16'hFFFE) periph_buf <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] b);
    pre_we = 1'b1; pre_addr = a; pre_byte = b;
    cyc();
    pre_we = 1'b0;
  endtask

  int          base_we;
  int          stray;
  logic [7:0]  pre40;
  logic [1:0]  exp_ack;

  initial begin
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    pre_we = 0; pre_addr = 0; pre_byte = 0;
    we_cnt = 0; periph_buf = 0;
    cyc();
    preload(16'h0010, 8'h34);
    preload(16'h0011, 8'h12);
    preload(16'h0020, 8'h78);
    preload(16'h0021, 8'h56);

    // Reset state
    chk("rst_ack", {ack1, ack0}, 2'b00);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Single read
    base_we = we_cnt;
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    cyc();
    chk("rd_access_addr", ram_addr, 16'h0010);
    chk("rd_access_ack", {ack1, ack0}, 2'b00);
    chk("rd_busy", busy, 1'b1);
    cyc();
    chk("rd_ack", {ack1, ack0}, 2'b01);
    chk("rd_rdata", rdata, 16'h1234);
    req0 = 0;
    cyc();
    chk("rd_ack_drop", {ack1, ack0}, 2'b00);
    chk("rd_idle_busy", busy, 1'b0);
    chk("rd_rdata_hold", rdata, 16'h1234);
    chk("rd_idle_addr", ram_addr, 16'h0000);
    chk("rd_no_we", we_cnt - base_we, 0);

    // Single write to the peripheral buffer
    base_we = we_cnt;
    req1 = 1; we1 = 1; addr1 = 16'hFFFE; wdata1 = 16'hBEEF;
    cyc();
    chk("wr_ram_we", ram_we, 1'b1);
    chk("wr_ram_addr", ram_addr, 16'hFFFE);
    chk("wr_ram_wdata", ram_wdata, 16'hBEEF);
    chk("wr_early_ack", {ack1, ack0}, 2'b00);
    cyc();
    chk("wr_ack", {ack1, ack0}, 2'b10);
    chk("wr_periph_buf", periph_buf, 16'hBEEF);
    chk("wr_ram_we_low", ram_we, 1'b0);
    chk("wr_rdata", rdata, 16'hBEEF);
    req1 = 0; we1 = 0;
    cyc();
    chk("wr_we_once", we_cnt - base_we, 1);

    // Contention from reset: grants 0,1,0,1 three cycles apart
    rst_n = 1'b0;
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    req1 = 1; we1 = 0; addr1 = 16'hFFFE;
    cyc();
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      exp_ack = 2'b00;
      if (c == 2 || c == 8)  exp_ack = 2'b01;
      if (c == 5 || c == 11) exp_ack = 2'b10;
      chk($sformatf("cont_ack_c%0d", c), {ack1, ack0}, exp_ack);
      if (c == 2) chk("cont_rdata0", rdata, 16'h1234);
      if (c == 5) chk("cont_rdata1", rdata, 16'hBEEF);
    end
    req0 = 0; req1 = 0;
    cyc();
    cyc();

    // Lock: read-modify-write on port 1 while port 0 waits
    req1 = 1; we1 = 0; addr1 = 16'h0020; lock1 = 1;
    cyc();
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    cyc();
    chk("lk_rd_ack", {ack1, ack0}, 2'b10);
    chk("lk_rd_rdata", rdata, 16'h5678);
    we1 = 1; wdata1 = 16'h9ABC; lock1 = 0;
    cyc();
    chk("lk_idle_busy", busy, 1'b1);
    cyc();
    chk("lk_wr_we", ram_we, 1'b1);
    chk("lk_wr_addr", ram_addr, 16'h0020);
    cyc();
    chk("lk_wr_ack", {ack1, ack0}, 2'b10);
    req1 = 0; we1 = 0;
    cyc();
    chk("lk_mem", {mem[16'h0021], mem[16'h0020]}, 16'h9ABC);
    cyc();
    chk("lk_p0_access", ram_addr, 16'h0010);
    cyc();
    chk("lk_p0_ack", {ack1, ack0}, 2'b01);
    req0 = 0;
    cyc();

    // Lock timeout: lock with no follow-up, port 0 waits 16 idle cycles
    req1 = 1; we1 = 0; addr1 = 16'h0020; lock1 = 1;
    cyc();
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    cyc();
    chk("to_ack1", {ack1, ack0}, 2'b10);
    chk("to_rdata", rdata, 16'h9ABC);
    req1 = 0; lock1 = 0;
    stray = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (ack0 || ack1 || ram_addr != 16'h0000 || !busy) stray++;
    end
    chk("to_wait_locked", stray, 0);
    cyc();
    chk("to_released_busy", busy, 1'b0);
    cyc();
    chk("to_p0_access", ram_addr, 16'h0010);
    cyc();
    chk("to_p0_ack", {ack1, ack0}, 2'b01);
    req0 = 0;
    cyc();

    // Reset in the middle of a write ACCESS
    pre40 = mem[16'h0040];
    req0 = 1; we0 = 1; addr0 = 16'h0040; wdata0 = 16'h1111;
    cyc();
    chk("mr_we_before", ram_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_we_drop", ram_we, 1'b0);
    chk("mr_ack", {ack1, ack0}, 2'b00);
    chk("mr_busy", busy, 1'b0);
    req0 = 0; we0 = 0;
    cyc();
    chk("mr_no_write", mem[16'h0040], pre40);
    chk("mr_rdata_clr", rdata, 16'h0000);
    rst_n = 1'b1;
    req0 = 1; addr0 = 16'h0010;
    req1 = 1; we1 = 0; addr1 = 16'hFFFE;
    cyc();
    cyc();
    chk("mr_prio_ack", {ack1, ack0}, 2'b01);
    chk("mr_prio_rdata", rdata, 16'h1234);
    req0 = 0;
    cyc();
    cyc();
    cyc();
    chk("mr_p1_ack", {ack1, ack0}, 2'b10);
    req1 = 0;
    cyc();

    // Odd address wrapping past 0xFFFF
    req0 = 1; we0 = 1; addr0 = 16'hFFFF; wdata0 = 16'hA55A;
    cyc();
    chk("wrap_we", ram_we, 1'b1);
    chk("wrap_addr", ram_addr, 16'hFFFF);
    cyc();
    chk("wrap_ack", {ack1, ack0}, 2'b01);
    chk("wrap_hi", mem[16'hFFFF], 8'h5A);
    chk("wrap_lo", mem[16'h0000], 8'hA5);
    chk("wrap_periph_kept", periph_buf, 16'hBEEF);
    req0 = 0; we0 = 0;
    cyc();
    chk("end_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
